// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and control-code definitions for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SHL2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;
  // Unsupported opcodes map to FETCH, which doubles as the illegal-opcode marker
  function automatic state_t decode_next(input logic [5:0] op);
    return op == OP_R ? S_RTEXEC :
           (op == OP_LW || op == OP_SW) ? S_MEMADR :
           op == OP_BEQ ? S_BRANCH :
           (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_SLTI) ? S_IEXEC :
           op == OP_J ? S_JUMP : S_FETCH;
  endfunction
  function automatic logic op_illegal(input logic [5:0] op);
    return decode_next(op) == S_FETCH;
  endfunction
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath control bundle
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOP;
  logic [1:0] PCSrc;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;
  modport master (
    input  opcode, zero, mem_ready,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOP, PCSrc, instr_done, illegal_op, state
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOP, PCSrc, instr_done, illegal_op, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational map from controller state to datapath controls
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] op_q_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);
  // Per-state control word; only completion-gated enables and the branch PCEn look at inputs
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_4;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_SHL2;
        ctrl_o.illegal_op = op_illegal(opcode_i);
        ctrl_o.instr_done = op_illegal(opcode_i);
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_RTEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_B;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_src     = PC_ALUOUT;
        ctrl_o.pc_en      = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_IEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = imm_aluop(op_q_i);
      end
      S_IWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src     = PC_JUMP;
        ctrl_o.pc_en      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: state sequencer for the shared-resource multicycle MIPS datapath
module multicycle_controller
  import mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic clk,
  input  logic rst,
  multicycle_controller_if.master bus
);
  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_t      ctrl, ctrl_g;
  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .op_q_i      (op_q),
    .zero_i      (bus.zero),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );
  // Next state; opcode is captured only while in DECODE, unreachable codes fall back to FETCH
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = decode_next(bus.opcode);
      end
      S_MEMADR: state_d = op_q == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXEC: state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end
  // State and captured-opcode registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_t'(RESET_STATE);
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end
  // Reset masks every output so an abandoned instruction cannot leak a write enable
  assign ctrl_g         = rst ? '0 : ctrl;
  assign bus.PCEn       = ctrl_g.pc_en;
  assign bus.IorD       = ctrl_g.iord;
  assign bus.MemRead    = ctrl_g.mem_read;
  assign bus.MemWrite   = ctrl_g.mem_write;
  assign bus.IRWrite    = ctrl_g.ir_write;
  assign bus.RegDst     = ctrl_g.reg_dst;
  assign bus.MemtoReg   = ctrl_g.mem_to_reg;
  assign bus.RegWrite   = ctrl_g.reg_write;
  assign bus.ALUSrcA    = ctrl_g.alu_src_a;
  assign bus.ALUSrcB    = ctrl_g.alu_src_b;
  assign bus.ALUOP      = ctrl_g.alu_op;
  assign bus.PCSrc      = ctrl_g.pc_src;
  assign bus.instr_done = ctrl_g.instr_done;
  assign bus.illegal_op = ctrl_g.illegal_op;
  assign bus.state      = rst ? 4'd0 : state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: instruction-table scoreboard bench for the multicycle controller
module tb_multicycle_controller;
  typedef struct {
    logic [5:0] op;
    logic       z;
    int         wf;
    int         wm;
  } instr_t;
  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic        z;
    logic [5:0]  dop;
    logic [18:0] exp;
  } step_t;
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     errors = 0;
  step_t  sb[$];
  instr_t tbl[13];
  multicycle_controller_if bus ();
  multicycle_controller #(.RESET_STATE(4'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [18:0] act();
    return {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOP, bus.PCSrc,
            bus.instr_done, bus.illegal_op};
  endfunction
  function automatic logic [18:0] exp_out(input logic [3:0] st, input logic mr, input logic z,
                                          input logic [5:0] op);
    logic pcen, iord, mrd, mwr, irw, rdst, m2r, rw, sa, done, ill;
    logic [1:0] srcb, pcs;
    logic [2:0] aop;
    logic legal;
    {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, sa, done, ill} = '0;
    srcb = 2'b00;
    pcs = 2'b00;
    aop = 3'b000;
    legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                       6'b001000, 6'b001100, 6'b001101, 6'b001010};
    case (st)
      4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcen = mr; end
      4'd1:  begin srcb = 2'b11; ill = !legal; done = !legal; end
      4'd2:  begin sa = 1; srcb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mwr = 1; iord = 1; done = mr; end
      4'd6:  begin sa = 1; aop = 3'b010; end
      4'd7:  begin rw = 1; rdst = 1; done = 1; end
      4'd8:  begin sa = 1; aop = 3'b001; pcs = 2'b01; pcen = z; done = 1; end
      4'd9:  begin
        sa = 1;
        srcb = 2'b10;
        aop = op == 6'b001100 ? 3'b011 : op == 6'b001101 ? 3'b101 : op == 6'b001010 ? 3'b100 : 3'b000;
      end
      4'd10: begin rw = 1; done = 1; end
      4'd11: begin pcs = 2'b10; pcen = 1; done = 1; end
      default: ;
    endcase
    return {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, sa, srcb, aop, pcs, done, ill};
  endfunction
  task automatic check(input string name, input logic [18:0] a, input logic [18:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, a, e);
    end
  endtask
  // Outside FETCH/DECODE the opcode bus carries junk so only the captured copy can matter
  task automatic add(input logic [3:0] st, input logic mr, input logic z, input logic [5:0] op);
    step_t s;
    s.st  = st;
    s.mr  = mr;
    s.z   = st == 4'd8 ? z : 1'($urandom);
    s.dop = st <= 4'd1 ? op : 6'($urandom);
    s.exp = exp_out(st, s.mr, s.z, op);
    sb.push_back(s);
  endtask
  task automatic plan(input instr_t t);
    for (int i = 0; i < t.wf; i++) add(4'd0, 1'b0, t.z, t.op);
    add(4'd0, 1'b1, t.z, t.op);
    add(4'd1, 1'($urandom), t.z, t.op);
    case (t.op)
      6'b000000: begin add(4'd6, 1'($urandom), t.z, t.op); add(4'd7, 1'($urandom), t.z, t.op); end
      6'b100011: begin
        add(4'd2, 1'($urandom), t.z, t.op);
        for (int i = 0; i < t.wm; i++) add(4'd3, 1'b0, t.z, t.op);
        add(4'd3, 1'b1, t.z, t.op);
        add(4'd4, 1'($urandom), t.z, t.op);
      end
      6'b101011: begin
        add(4'd2, 1'($urandom), t.z, t.op);
        for (int i = 0; i < t.wm; i++) add(4'd5, 1'b0, t.z, t.op);
        add(4'd5, 1'b1, t.z, t.op);
      end
      6'b000100: add(4'd8, 1'($urandom), t.z, t.op);
      6'b000010: add(4'd11, 1'($urandom), t.z, t.op);
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        add(4'd9, 1'($urandom), t.z, t.op);
        add(4'd10, 1'($urandom), t.z, t.op);
      end
      default: ;
    endcase
  endtask
  task automatic run();
    step_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      bus.opcode = s.dop;
      bus.zero = s.z;
      bus.mem_ready = s.mr;
      #1;
      check("state", 19'(bus.state), 19'(s.st));
      check("ctrl", act(), s.exp);
    end
  endtask
  initial begin
    tbl[0]  = '{6'b000000, 1'b0, 0, 0};
    tbl[1]  = '{6'b100011, 1'b0, 0, 2};
    tbl[2]  = '{6'b101011, 1'b0, 1, 0};
    tbl[3]  = '{6'b000100, 1'b1, 0, 0};
    tbl[4]  = '{6'b000100, 1'b0, 0, 0};
    tbl[5]  = '{6'b001101, 1'b0, 0, 0};
    tbl[6]  = '{6'b001000, 1'b0, 0, 0};
    tbl[7]  = '{6'b111111, 1'b0, 0, 0};
    tbl[8]  = '{6'b001100, 1'b0, 0, 0};
    tbl[9]  = '{6'b001010, 1'b0, 0, 0};
    tbl[10] = '{6'b000010, 1'b0, 0, 0};
    tbl[11] = '{6'b101011, 1'b0, 0, 3};
    tbl[12] = '{6'b100011, 1'b0, 2, 0};
    bus.opcode = 6'b0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 19'(bus.state), 19'd0);
    check("reset_ctrl", act(), 19'd0);
    rst = 1'b0;
    foreach (tbl[i]) plan(tbl[i]);
    add(4'd0, 1'b0, 1'b0, 6'b000000);
    run();
    add(4'd0, 1'b1, 1'b0, 6'b101011);
    add(4'd1, 1'b1, 1'b0, 6'b101011);
    add(4'd2, 1'b1, 1'b0, 6'b101011);
    add(4'd5, 1'b0, 1'b0, 6'b101011);
    run();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("rst_cycle_ctrl", act(), 19'd0);
    check("rst_cycle_state", 19'(bus.state), 19'd0);
    @(negedge clk);
    #1;
    check("post_rst_ctrl", act(), 19'd0);
    check("post_rst_state", 19'(bus.state), 19'd0);
    rst = 1'b0;
    plan('{6'b001101, 1'b0, 0, 0});
    add(4'd0, 1'b0, 1'b0, 6'b000000);
    run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
